// File: rtl/priority_encoder_8x3_seq_if.sv
// Request-in / index-out handshake bundle for the sequential 8-to-3 priority encoder.
// The slave side is the encoder; the master side is the producer/consumer pair.
interface priority_encoder_8x3_seq_if;
    localparam int unsigned VEC_W  = 8;
    localparam int unsigned CODE_W = 3;

    logic              in_valid;
    logic [VEC_W-1:0]  in_vec;
    logic              in_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              out_none;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_last,
        input  out_none
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output out_last,
        output out_none
    );
endinterface

// File: rtl/priority_encoder_8x3_seq.sv
// Sequential 8-to-3 priority encoder: accepts an 8-bit request vector and emits the
// index of each set bit, one beat per cycle, lowest-first or highest-first.
module priority_encoder_8x3_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    priority_encoder_8x3_seq_if.slave   bus
);
    localparam int unsigned VEC_W  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [VEC_W-1:0]   pending;
    logic [VEC_W-1:0]   pending_nxt;
    logic               none;
    logic               none_nxt;

    logic [CODE_W-1:0]  code;
    logic               single;
    logic               last_beat;
    logic               xfer;
    logic               accept;

    // Index of the highest-priority set bit; 0 when the vector is empty.
    function automatic logic [CODE_W-1:0] prio_index(input logic [VEC_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(VEC_W); i++) begin
                if (v[i]) idx = CODE_W'(i);
            end
        end else begin
            for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
                if (v[i]) idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // Beat decode from registered state only.
    always_comb begin
        code      = prio_index(pending);
        single    = (pending != '0) && ((pending & (pending - VEC_W'(1))) == '0);
        last_beat = none || single;
    end

    // Handshake qualifiers; in_ready has a deliberate path from out_ready.
    always_comb begin
        xfer   = (state == EMIT) && !rst && bus.out_ready;
        accept = bus.in_valid && bus.in_ready;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            none    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            none    <= none_nxt;
        end
    end

    // Next state: a same-cycle acceptance overrides the return to IDLE.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        none_nxt    = none;
        if (xfer) begin
            pending_nxt = pending & ~(VEC_W'(1) << code);
            if (last_beat) begin
                state_nxt = IDLE;
                none_nxt  = 1'b0;
            end
        end
        if (accept) begin
            state_nxt   = EMIT;
            pending_nxt = bus.in_vec;
            none_nxt    = (bus.in_vec == '0);
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_code  = '0;
        bus.out_last  = 1'b0;
        bus.out_none  = 1'b0;
        if (!rst) begin
            bus.in_ready = (state == IDLE) || (xfer && last_beat);
            if (state == EMIT) begin
                bus.out_valid = 1'b1;
                bus.out_code  = none ? '0 : code;
                bus.out_last  = last_beat;
                bus.out_none  = none;
            end
        end
    end
endmodule

// File: tb/tb_priority_encoder_8x3_seq.sv
// Scoreboard bench: one LSB-first and one MSB-first encoder driven with identical
// stimulus; expected beats are derived from each accepted vector's set bits.
module tb_priority_encoder_8x3_seq;
    typedef struct packed {
        logic [2:0] code;
        logic       last;
        logic       none;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst;
    beat_t q0[$];
    beat_t q1[$];
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    priority_encoder_8x3_seq_if bus0 ();
    priority_encoder_8x3_seq_if bus1 ();

    priority_encoder_8x3_seq #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    priority_encoder_8x3_seq #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic void chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s dut%0d @%0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
    endfunction

    function automatic void qpush(input int d, input beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int d);
        beat_t b;
        if (d == 0) b = q0.pop_front();
        else        b = q1.pop_front();
    endfunction

    // Reference: list set bits in priority order; an empty vector is one "none" beat.
    function automatic void expect_vec(input int d, input logic [7:0] vec);
        beat_t b;
        int    k;
        int    seen;
        int    i;
        k    = $countones(vec);
        seen = 0;
        if (vec == 8'h00) begin
            b.code = 3'd0;
            b.last = 1'b1;
            b.none = 1'b1;
            qpush(d, b);
        end else begin
            for (int j = 0; j < 8; j++) begin
                i = (d == 1) ? 7 - j : j;
                if (vec[i]) begin
                    seen++;
                    b.code = 3'(i);
                    b.last = (seen == k);
                    b.none = 1'b0;
                    qpush(d, b);
                end
            end
        end
    endfunction

    function automatic void monitor_port(input int d, input logic ov, input logic [2:0] code,
                                         input logic last, input logic none, input logic ir,
                                         input logic ordy);
        int    n;
        beat_t b;
        n = qsize(d);
        if (rst) begin
            chk("reset_outputs", d, {1'b0, ov, code, last, none, ir}, 8'h00);
        end else begin
            chk("in_ready", d, {7'd0, ir}, {7'd0, (n == 0) || (n == 1 && ordy)});
            chk("out_valid", d, {7'd0, ov}, {7'd0, n != 0});
            if (ov && n != 0) begin
                b = qfront(d);
                chk("beat", d, {3'd0, code, last, none}, {3'd0, b});
                if (ordy) qpop(d);
            end
        end
    endfunction

    always @(negedge clk) begin
        monitor_port(0, bus0.out_valid, bus0.out_code, bus0.out_last, bus0.out_none,
                     bus0.in_ready, bus0.out_ready);
        monitor_port(1, bus1.out_valid, bus1.out_code, bus1.out_last, bus1.out_none,
                     bus1.in_ready, bus1.out_ready);
    end

    // One cycle of stimulus; accepted vectors are scored just after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] vec, input logic ordy);
        logic a0;
        logic a1;
        rst = r;
        if (r) begin
            q0.delete();
            q1.delete();
        end
        bus0.in_valid  = v;
        bus0.in_vec    = vec;
        bus0.out_ready = ordy;
        bus1.in_valid  = v;
        bus1.in_vec    = vec;
        bus1.out_ready = ordy;
        @(negedge clk);
        a0 = bus0.in_valid && bus0.in_ready;
        a1 = bus1.in_valid && bus1.in_ready;
        @(posedge clk);
        #1;
        if (a0) expect_vec(0, vec);
        if (a1) expect_vec(1, vec);
    endtask

    initial begin
        logic [7:0] rv;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'h01, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'hA5, 1'b1);
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'h00, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'h81, 1'b0);
        repeat (3) step(1'b0, 1'b1, 8'h3C, 1'b0);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'h03, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);

        step(1'b0, 1'b1, 8'hFF, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h10, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);

        repeat (2000) begin
            rv = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), rv,
                 ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++)
            step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_empty", 0, 8'(q0.size() + q1.size()), 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
